riscv_ex_mem_wb: RTL and testbench

- Back half of the 5-stage RISC-V pipeline: ID/EX, EX, EX/MEM, MEM (data memory) and MEM/WB stages.
- Consumes the decoded outputs of the IF/ID front end.
- Drives back the front end's control inputs: IF_ID_write, PC_write, PCSrc, PC_Branch, RegWrite_WB, ALU_DATA_WB, RD_WB.
- Owns forwarding, load-use stall and branch flush.

---
 rtl/riscv_ex_mem_wb.sv | 243 ++++++++++++++++++++++++
 tb/tb_riscv_ex_mem_wb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_mem_wb.sv
// Back half of a 5-stage RISC-V pipeline: ID/EX, EX, EX/MEM, MEM and MEM/WB.
// Handles operand forwarding, the load-use stall and the taken-branch flush.
module riscv_ex_mem_wb #(
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_ID,
   input  logic [31:0] IMM_ID,
   input  logic [31:0] REG_DATA1_ID,
   input  logic [31:0] REG_DATA2_ID,
   input  logic [2:0]  FUNCT3_ID,
   input  logic [6:0]  FUNCT7_ID,
   input  logic [6:0]  OPCODE_ID,
   input  logic [4:0]  RD_ID,
   input  logic [4:0]  RS1_ID,
   input  logic [4:0]  RS2_ID,
   output logic        IF_ID_write,
   output logic        PC_write,
   output logic        PCSrc,
   output logic [31:0] PC_Branch,
   output logic        RegWrite_WB,
   output logic [31:0] ALU_DATA_WB,
   output logic [4:0]  RD_WB
);
   localparam int AW = $clog2(DMEM_WORDS);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
   } alu_op_t;

   // ID-stage decode results
   alu_op_t     id_alu;
   logic        id_wr, id_ld, id_st, id_br, id_bne, id_imm_sel, uses_rs2;
   logic [31:0] id_a, id_b;
   logic        load_use, stall, load_id, squash;

   // ID/EX register
   logic        idex_valid, idex_wr, idex_ld, idex_st, idex_br, idex_bne, idex_imm_sel;
   alu_op_t     idex_alu;
   logic [31:0] idex_pc, idex_imm, idex_a, idex_b;
   logic [4:0]  idex_rd, idex_rs1, idex_rs2;

   // EX-stage values
   logic [31:0] fwd_a, fwd_b, alu_b, alu_res;
   logic        taken;

   // EX/MEM register
   logic        exmem_valid, exmem_wr, exmem_ld, exmem_st, exmem_taken;
   logic [31:0] exmem_alu, exmem_store, exmem_target;
   logic [4:0]  exmem_rd;

   // Data memory and MEM/WB register
   logic [31:0]   dmem [DMEM_WORDS];
   logic [AW-1:0] mem_addr;
   logic [31:0]   load_data;
   logic          memwb_valid, memwb_wr;
   logic [31:0]   memwb_data;
   logic [4:0]    memwb_rd;

   // Decode the instruction in ID into control bits; unknown encodings decode as NOP
   always_comb begin
      id_alu     = ALU_ADD;
      id_wr      = 1'b0;
      id_ld      = 1'b0;
      id_st      = 1'b0;
      id_br      = 1'b0;
      id_bne     = 1'b0;
      id_imm_sel = 1'b0;
      case (OPCODE_ID)
         OP_R: begin
            id_wr = 1'b1;
            case (FUNCT3_ID)
               3'b000:  id_alu = (FUNCT7_ID == 7'b0100000) ? ALU_SUB : ALU_ADD;
               3'b111:  id_alu = ALU_AND;
               3'b110:  id_alu = ALU_OR;
               3'b100:  id_alu = ALU_XOR;
               3'b010:  id_alu = ALU_SLT;
               3'b001:  id_alu = ALU_SLL;
               3'b101:  id_alu = ALU_SRL;
               default: id_wr  = 1'b0;
            endcase
         end
         OP_I: begin
            id_wr      = 1'b1;
            id_imm_sel = 1'b1;
            case (FUNCT3_ID)
               3'b000:  id_alu = ALU_ADD;
               3'b111:  id_alu = ALU_AND;
               3'b110:  id_alu = ALU_OR;
               3'b100:  id_alu = ALU_XOR;
               3'b010:  id_alu = ALU_SLT;
               default: id_wr  = 1'b0;
            endcase
         end
         OP_LW: begin
            if (FUNCT3_ID == 3'b010) begin
               id_wr      = 1'b1;
               id_ld      = 1'b1;
               id_imm_sel = 1'b1;
            end
         end
         OP_SW: begin
            if (FUNCT3_ID == 3'b010) begin
               id_st      = 1'b1;
               id_imm_sel = 1'b1;
            end
         end
         OP_BR: begin
            case (FUNCT3_ID)
               3'b000:  id_br = 1'b1;
               3'b001:  begin id_br = 1'b1; id_bne = 1'b1; end
               default: id_br = 1'b0;
            endcase
         end
         default: id_wr = 1'b0;
      endcase
   end

   // Load-use hazard detection and WB-to-ID bypass; flush and squash override the stall
   always_comb begin
      uses_rs2    = (OPCODE_ID == OP_R) || (OPCODE_ID == OP_SW) || (OPCODE_ID == OP_BR);
      load_use    = idex_valid && idex_ld && (idex_rd != 5'd0) &&
                    ((idex_rd == RS1_ID) || (uses_rs2 && (idex_rd == RS2_ID)));
      stall       = load_use && !PCSrc && !squash;
      load_id     = !(PCSrc || squash || stall);
      IF_ID_write = !stall;
      PC_write    = !stall;
      id_a        = (RegWrite_WB && (RD_WB == RS1_ID)) ? ALU_DATA_WB : REG_DATA1_ID;
      id_b        = (RegWrite_WB && (RD_WB == RS2_ID)) ? ALU_DATA_WB : REG_DATA2_ID;
   end

   // ID/EX register: bubbles carry no control, so they can never write or branch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idex_valid <= 1'b0; idex_wr <= 1'b0; idex_ld <= 1'b0; idex_st <= 1'b0;
         idex_br <= 1'b0; idex_bne <= 1'b0; idex_imm_sel <= 1'b0; idex_alu <= ALU_ADD;
         idex_pc <= '0; idex_imm <= '0; idex_a <= '0; idex_b <= '0;
         idex_rd <= '0; idex_rs1 <= '0; idex_rs2 <= '0;
         squash <= 1'b0;
      end else begin
         idex_valid   <= load_id;
         idex_wr      <= load_id && id_wr;
         idex_ld      <= load_id && id_ld;
         idex_st      <= load_id && id_st;
         idex_br      <= load_id && id_br;
         idex_bne     <= id_bne;
         idex_imm_sel <= id_imm_sel;
         idex_alu     <= id_alu;
         idex_pc      <= PC_ID;
         idex_imm     <= IMM_ID;
         idex_a       <= id_a;
         idex_b       <= id_b;
         idex_rd      <= RD_ID;
         idex_rs1     <= RS1_ID;
         idex_rs2     <= RS2_ID;
         squash       <= PCSrc;
      end
   end

   // EX: forwarding muxes (EX/MEM before MEM/WB), ALU and branch comparison
   always_comb begin
      fwd_a = idex_a;
      if (idex_rs1 != 5'd0 && exmem_valid && exmem_wr && !exmem_ld && exmem_rd == idex_rs1)
         fwd_a = exmem_alu;
      else if (idex_rs1 != 5'd0 && RegWrite_WB && RD_WB == idex_rs1)
         fwd_a = ALU_DATA_WB;
      fwd_b = idex_b;
      if (idex_rs2 != 5'd0 && exmem_valid && exmem_wr && !exmem_ld && exmem_rd == idex_rs2)
         fwd_b = exmem_alu;
      else if (idex_rs2 != 5'd0 && RegWrite_WB && RD_WB == idex_rs2)
         fwd_b = ALU_DATA_WB;
      alu_b = idex_imm_sel ? idex_imm : fwd_b;
      case (idex_alu)
         ALU_ADD: alu_res = fwd_a + alu_b;
         ALU_SUB: alu_res = fwd_a - alu_b;
         ALU_AND: alu_res = fwd_a & alu_b;
         ALU_OR:  alu_res = fwd_a | alu_b;
         ALU_XOR: alu_res = fwd_a ^ alu_b;
         ALU_SLT: alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
         ALU_SLL: alu_res = fwd_a << alu_b[4:0];
         ALU_SRL: alu_res = fwd_a >> alu_b[4:0];
         default: alu_res = '0;
      endcase
      taken = idex_br && (idex_bne ? (fwd_a != fwd_b) : (fwd_a == fwd_b));
   end

   // EX/MEM register: a taken branch in EX/MEM kills the instruction now leaving EX
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exmem_valid <= 1'b0; exmem_wr <= 1'b0; exmem_ld <= 1'b0; exmem_st <= 1'b0;
         exmem_taken <= 1'b0; exmem_alu <= '0; exmem_store <= '0; exmem_rd <= '0;
         exmem_target <= '0;
      end else begin
         exmem_valid <= idex_valid && !PCSrc;
         exmem_wr    <= idex_valid && !PCSrc && idex_wr;
         exmem_ld    <= idex_valid && !PCSrc && idex_ld;
         exmem_st    <= idex_valid && !PCSrc && idex_st;
         exmem_taken <= idex_valid && !PCSrc && taken;
         exmem_alu   <= alu_res;
         exmem_store <= fwd_b;
         exmem_rd    <= idex_rd;
         if (idex_valid && !PCSrc && taken)
            exmem_target <= idex_pc + idex_imm;
      end
   end

   assign PCSrc     = exmem_valid && exmem_taken;
   assign PC_Branch = exmem_target;
   assign mem_addr  = exmem_alu[AW+1:2];
   assign load_data = dmem[mem_addr];

   // Data memory: word-addressed, cleared on reset, written by stores leaving MEM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
      end else if (exmem_valid && exmem_st) begin
         dmem[mem_addr] <= exmem_store;
      end
   end

   // MEM/WB register: selects load data or ALU result for write-back
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memwb_valid <= 1'b0; memwb_wr <= 1'b0; memwb_data <= '0; memwb_rd <= '0;
      end else begin
         memwb_valid <= exmem_valid;
         memwb_wr    <= exmem_valid && exmem_wr;
         memwb_data  <= exmem_ld ? load_data : exmem_alu;
         memwb_rd    <= exmem_rd;
      end
   end

   assign RegWrite_WB = memwb_valid && memwb_wr && (memwb_rd != 5'd0);
   assign ALU_DATA_WB = memwb_data;
   assign RD_WB       = memwb_rd;
endmodule

// File: tb/tb_riscv_ex_mem_wb.sv
// Directed bench for riscv_ex_mem_wb with a write-back scoreboard.
module tb_riscv_ex_mem_wb;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   logic        clk, reset;
   logic [31:0] PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
   logic [2:0]  FUNCT3_ID;
   logic [6:0]  FUNCT7_ID, OPCODE_ID;
   logic [4:0]  RD_ID, RS1_ID, RS2_ID;
   logic        IF_ID_write, PC_write, PCSrc, RegWrite_WB;
   logic [31:0] PC_Branch, ALU_DATA_WB;
   logic [4:0]  RD_WB;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          due;
   } wb_t;

   wb_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;

   riscv_ex_mem_wb #(.DMEM_WORDS(64)) dut (
      .clk(clk), .reset(reset),
      .PC_ID(PC_ID), .IMM_ID(IMM_ID), .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
      .FUNCT3_ID(FUNCT3_ID), .FUNCT7_ID(FUNCT7_ID), .OPCODE_ID(OPCODE_ID),
      .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
      .IF_ID_write(IF_ID_write), .PC_write(PC_write), .PCSrc(PCSrc), .PC_Branch(PC_Branch),
      .RegWrite_WB(RegWrite_WB), .ALU_DATA_WB(ALU_DATA_WB), .RD_WB(RD_WB)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to time scoreboard entries
   always @(posedge clk) cyc++;

   // Safety net against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] pc);
      OPCODE_ID = op; FUNCT3_ID = f3; FUNCT7_ID = f7;
      RD_ID = rd; RS1_ID = rs1; RS2_ID = rs2;
      IMM_ID = imm; REG_DATA1_ID = d1; REG_DATA2_ID = d2; PC_ID = pc;
   endtask

   task automatic addi(input logic [4:0] rd, input logic [31:0] imm);
      apply_stimulus(OP_I, 3'b000, 7'd0, rd, 5'd0, 5'd0, imm, 32'd0, 32'd0, 32'h100);
   endtask

   task automatic nop();
      apply_stimulus(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
      wb_t e;
      e.rd = rd; e.data = data; e.due = cyc + 3;
      sb.push_back(e);
   endtask

   task automatic drain();
      nop();
      repeat (6) step();
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_regwrite"}, RegWrite_WB, 0);
      check_output({tag, "_data"}, ALU_DATA_WB, 0);
      check_output({tag, "_rd"}, RD_WB, 0);
      check_output({tag, "_pcsrc"}, PCSrc, 0);
      check_output({tag, "_pcbranch"}, PC_Branch, 0);
      check_output({tag, "_ifid_write"}, IF_ID_write, 1);
      check_output({tag, "_pc_write"}, PC_write, 1);
   endtask

   // Scoreboard: every write-back must match the oldest expectation at its due cycle
   always @(negedge clk) begin
      wb_t e;
      if (reset) begin
         if (sb.size() > 0) begin
            checks++;
            assert (sb[0].due >= cyc) else begin
               errors++;
               $error("[TB] FAIL missed_wb observed no write expected rd %0d data %h", sb[0].rd, sb[0].data);
               void'(sb.pop_front());
            end
         end
         if (RegWrite_WB) begin
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("[TB] FAIL unexpected_wb observed rd %0d data %h expected no write", RD_WB, ALU_DATA_WB);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check_output("wb_rd", RD_WB, e.rd);
               check_output("wb_data", ALU_DATA_WB, e.data);
               check_output("wb_cycle", cyc, e.due);
            end
         end
      end
   end

   // Directed sequence
   initial begin
      reset = 1'b0;
      addi(5'd1, 32'd5);
      repeat (3) begin
         step();
         check_reset_values("reset_hold");
      end
      reset = 1'b1;
      drain();

      // Basic ADDI latency
      addi(5'd1, 32'd5); expect_wb(5'd1, 32'd5); step();
      drain();

      // EX/MEM forwarding
      addi(5'd1, 32'd5); expect_wb(5'd1, 32'd5); step();
      apply_stimulus(OP_R, 3'b000, 7'd0, 5'd2, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 32'h104);
      expect_wb(5'd2, 32'd10); step();
      drain();

      // MEM/WB forwarding with one-instruction gap
      addi(5'd1, 32'd5); expect_wb(5'd1, 32'd5); step();
      nop(); step();
      apply_stimulus(OP_R, 3'b000, 7'd0, 5'd2, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 32'h108);
      expect_wb(5'd2, 32'd10); step();
      drain();

      // WB-to-ID bypass with two-instruction gap, SUB
      addi(5'd1, 32'd7); expect_wb(5'd1, 32'd7); step();
      nop(); step();
      nop(); step();
      apply_stimulus(OP_R, 3'b000, 7'b0100000, 5'd2, 5'd1, 5'd0, 32'd0, 32'd0, 32'd0, 32'h10C);
      expect_wb(5'd2, 32'd7); step();
      drain();

      // Load-use: store, load, dependent add with one stall cycle
      addi(5'd5, 32'h2A); expect_wb(5'd5, 32'h2A); step();
      apply_stimulus(OP_SW, 3'b010, 7'd0, 5'd0, 5'd0, 5'd5, 32'd8, 32'd0, 32'd0, 32'h110);
      step();
      apply_stimulus(OP_LW, 3'b010, 7'd0, 5'd3, 5'd0, 5'd0, 32'd8, 32'd0, 32'd0, 32'h114);
      expect_wb(5'd3, 32'h2A); step();
      apply_stimulus(OP_R, 3'b000, 7'd0, 5'd4, 5'd3, 5'd3, 32'd0, 32'd0, 32'd0, 32'h118);
      #1;
      check_output("stall_ifid_write", IF_ID_write, 0);
      check_output("stall_pc_write", PC_write, 0);
      step();
      expect_wb(5'd4, 32'h54);
      #1;
      check_output("after_stall_ifid_write", IF_ID_write, 1);
      check_output("after_stall_pc_write", PC_write, 1);
      step();
      drain();

      // Taken BEQ flushes the next three instructions
      apply_stimulus(OP_BR, 3'b000, 7'd0, 5'd0, 5'd6, 5'd7, 32'h10, 32'h99, 32'h99, 32'h20);
      step();
      check_output("beq_pcsrc_t1", PCSrc, 0);
      addi(5'd8, 32'd1); step();
      check_output("beq_pcsrc_t2", PCSrc, 1);
      check_output("beq_target", PC_Branch, 32'h30);
      addi(5'd9, 32'd2); step();
      check_output("beq_pcsrc_t3", PCSrc, 0);
      addi(5'd10, 32'd3); step();
      drain();

      // Not-taken BNE: following instructions complete normally
      apply_stimulus(OP_BR, 3'b001, 7'd0, 5'd0, 5'd6, 5'd7, 32'h10, 32'h99, 32'h99, 32'h20);
      step();
      check_output("bne_pcsrc_t1", PCSrc, 0);
      addi(5'd8, 32'd1); expect_wb(5'd8, 32'd1); step();
      check_output("bne_pcsrc_t2", PCSrc, 0);
      addi(5'd9, 32'd2); expect_wb(5'd9, 32'd2); step();
      check_output("bne_pcsrc_t3", PCSrc, 0);
      addi(5'd10, 32'd3); expect_wb(5'd10, 32'd3); step();
      drain();

      // Asynchronous reset mid-cycle with writes in flight
      addi(5'd11, 32'd11); step();
      addi(5'd12, 32'd12); step();
      addi(5'd13, 32'd13);
      @(posedge clk);
      #2;
      check_output("pre_reset_regwrite", RegWrite_WB, 1);
      check_output("pre_reset_rd", RD_WB, 11);
      reset = 1'b0;
      #1;
      check_reset_values("async_reset");
      step();
      nop();
      step();
      reset = 1'b1;
      drain();

      // Memory cleared by reset: load from the previously stored word returns zero
      apply_stimulus(OP_LW, 3'b010, 7'd0, 5'd3, 5'd0, 5'd0, 32'd8, 32'd0, 32'd0, 32'h120);
      expect_wb(5'd3, 32'd0); step();
      drain();

      check_output("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
